// File: rtl/div_result_bcd.sv
// Parallel double-dabble conversion of a divider's quotient and remainder into 3-digit BCD.
// Define DIV_BCD_BLANK_EN to replace leading zero digits with 4'hF on the outputs.
module div_result_bcd #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Q_in,
    input  logic [WIDTH-1:0] R_in,
    output logic [11:0]      q_bcd,
    output logic [11:0]      r_bcd,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] qbin_q, qbin_d, rbin_q, rbin_d;
    logic [11:0]      qacc_q, qacc_d, racc_q, racc_d;
    logic [11:0]      qout_q, qout_d, rout_q, rout_d;
    logic [11+WIDTH:0] q_step, r_step;

    // One double-dabble iteration: adjust digits >= 5, then shift {bcd, binary} left.
    function automatic logic [11+WIDTH:0] dabble_step(input logic [11:0] acc,
                                                      input logic [WIDTH-1:0] bin);
        logic [11:0]       adj;
        logic [11+WIDTH:0] v;
        for (int i = 0; i < 3; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = acc[4*i +: 4];
            end
        end
        v = {adj, bin};
        return {v[10+WIDTH:0], 1'b0};
    endfunction

    function automatic logic [11:0] fmt(input logic [11:0] bcd);
        logic [11:0] o;
        o = bcd;
`ifdef DIV_BCD_BLANK_EN
        if (o[11:8] == 4'd0) begin
            o[11:8] = 4'hF;
            if (o[7:4] == 4'd0) begin
                o[7:4] = 4'hF;
            end
        end
`endif
        return o;
    endfunction

    assign q_step = dabble_step(qacc_q, qbin_q);
    assign r_step = dabble_step(racc_q, rbin_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qbin_d  = qbin_q;
        rbin_d  = rbin_q;
        qacc_d  = qacc_q;
        racc_d  = racc_q;
        qout_d  = qout_q;
        rout_d  = rout_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    qbin_d  = Q_in;
                    rbin_d  = R_in;
                    qacc_d  = 12'd0;
                    racc_d  = 12'd0;
                    cnt_d   = CW'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {qacc_d, qbin_d} = q_step;
                {racc_d, rbin_d} = r_step;
                cnt_d = cnt_q - CW'(1);
                // Last shift: outputs take the freshly shifted accumulators directly.
                if (cnt_q == CW'(1)) begin
                    qout_d  = fmt(q_step[11+WIDTH:WIDTH]);
                    rout_d  = fmt(r_step[11+WIDTH:WIDTH]);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            qbin_q  <= '0;
            rbin_q  <= '0;
            qacc_q  <= '0;
            racc_q  <= '0;
            qout_q  <= '0;
            rout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qbin_q  <= qbin_d;
            rbin_q  <= rbin_d;
            qacc_q  <= qacc_d;
            racc_q  <= racc_d;
            qout_q  <= qout_d;
            rout_q  <= rout_d;
        end
    end

    assign q_bcd = qout_q;
    assign r_bcd = rout_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_div_result_bcd.sv
// Scoreboard bench for div_result_bcd: directed vectors plus a full 0..127 sweep.
module tb_div_result_bcd;

    localparam int unsigned WIDTH   = 7;
    localparam int unsigned LATENCY = WIDTH + 1;
`ifdef DIV_BCD_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] Q_in;
    logic [WIDTH-1:0] R_in;
    logic [11:0]      q_bcd;
    logic [11:0]      r_bcd;
    logic             busy;
    logic             done;

    div_result_bcd #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Q_in  (Q_in),
        .R_in  (R_in),
        .q_bcd (q_bcd),
        .r_bcd (r_bcd),
        .busy  (busy),
        .done  (done)
    );

    typedef struct {
        logic [11:0] exp_q;
        logic [11:0] exp_r;
        int          start_cyc;
    } exp_t;

    exp_t exp_q_fifo[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Decimal reference with optional leading-zero blanking.
    function automatic logic [11:0] model(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        if (BLANK && h == 4'd0) begin
            h = 4'hF;
            if (t == 4'd0) t = 4'hF;
        end
        return {h, t, u};
    endfunction

    function automatic logic [11:0] sel(input logic [11:0] plain, input logic [11:0] blanked);
        return BLANK ? blanked : plain;
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q_fifo.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done seen at cycle %0d with nothing pending", cyc);
            end else begin
                exp_t e;
                e = exp_q_fifo.pop_front();
                chk("q_bcd", q_bcd, e.exp_q);
                chk("r_bcd", r_bcd, e.exp_r);
                checks++;
                if (cyc - e.start_cyc != int'(LATENCY)) begin
                    errors++;
                    $display("FAIL latency: got %0d cycles expected %0d",
                             cyc - e.start_cyc, LATENCY);
                end
            end
        end
    end

    // Called #1 after a rising edge; holds start for one cycle.
    task automatic pulse(input int q, input int r, input bit expect_accept,
                         input logic [11:0] eq, input logic [11:0] er);
        exp_t e;
        start = 1'b1;
        Q_in  = WIDTH'(q);
        R_in  = WIDTH'(r);
        if (expect_accept) begin
            e.exp_q     = eq;
            e.exp_r     = er;
            e.start_cyc = cyc;
            exp_q_fifo.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", {11'd0, busy}, 12'd1);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within 20 cycles expected a done pulse");
        end
    endtask

    task automatic convert(input int q, input int r, input logic [11:0] eq,
                           input logic [11:0] er);
        @(posedge clk);
        #1;
        pulse(q, r, 1'b1, eq, er);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running expected finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        Q_in  = '0;
        R_in  = '0;
        #2 rst = 1'b0;
        #2;
        chk("reset_q_bcd", q_bcd, 12'h000);
        chk("reset_r_bcd", r_bcd, 12'h000);
        chk("reset_busy", {11'd0, busy}, 12'd0);
        chk("reset_done", {11'd0, done}, 12'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        convert(7, 1, sel(12'h007, 12'hFF7), sel(12'h001, 12'hFF1));
        convert(127, 0, 12'h127, sel(12'h000, 12'hFF0));
        convert(100, 10, 12'h100, sel(12'h010, 12'hF10));

        // Start during a conversion is dropped.
        @(posedge clk);
        #1;
        pulse(12, 3, 1'b1, sel(12'h012, 12'hF12), sel(12'h003, 12'hFF3));
        repeat (2) @(posedge clk);
        #1;
        pulse(99, 0, 1'b0, 12'h000, 12'h000);
        wait_done();
        repeat (12) @(negedge clk);
        chk("held_q_bcd", q_bcd, sel(12'h012, 12'hF12));
        chk("held_r_bcd", r_bcd, sel(12'h003, 12'hFF3));

        // Reset mid-conversion aborts and clears outputs.
        @(posedge clk);
        #1;
        pulse(63, 8, 1'b0, 12'h000, 12'h000);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_q_bcd", q_bcd, 12'h000);
        chk("abort_r_bcd", r_bcd, 12'h000);
        chk("abort_busy", {11'd0, busy}, 12'd0);
        chk("abort_done", {11'd0, done}, 12'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        pulse(5, 4, 1'b1, sel(12'h005, 12'hFF5), sel(12'h004, 12'hFF4));
        wait_done();

        // Back-to-back sweep; each start lands in the cycle right after done.
        for (int v = 0; v < 128; v++) begin
            convert(v, v, model(v), model(v));
        end

        repeat (12) @(negedge clk);
        checks++;
        if (exp_q_fifo.size() != 0) begin
            errors++;
            $display("FAIL pending_results: got %0d outstanding expected 0", exp_q_fifo.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
